// File: rtl/kfmmc_host_bridge.sv
// kfmmc_host_bridge
// Host-side register front end for the KFMMC drive. Host port reads and writes
// are edge-detected and decoded into one-cycle internal-bus strobes. Small
// byte FIFOs decouple the host from the drive in each direction. Sticky
// interrupt status, a mask and a per-block byte counter drive a level IRQ.
//
// Ports
//   clock, reset                 system clock, async active-low reset
//   chip_select, address         host register select / address
//   io_read, io_write            host access levels (synchronous to clock)
//   data_bus_in / data_bus_out   host write data / combinational read data
//   irq                          |(status & mask)
//   internal_data_bus            byte presented to the drive
//   write_block_address_1..4     block address byte strobes
//   write_access_command         command strobe
//   write_data                   write-path byte strobe
//   read_data                    pop acknowledge for an accepted drive byte
//   read_data_byte               drive read byte
//   drive_busy, *_error          drive state flags
//   *_interrupt                  drive event pulses / write-request level
//
// Write-path states
//   state     | meaning
//   W_IDLE    | waiting for a write request with the write FIFO non-empty
//   W_PRESENT | byte held on internal_data_bus (stalls while a host strobe owns it)
//   W_STROBE  | write_data asserted for one cycle
module kfmmc_host_bridge #(
    parameter int fifo_depth  = 4,
    parameter int block_bytes = 512
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       chip_select,
    input  logic [2:0] address,
    input  logic       io_read,
    input  logic       io_write,
    input  logic [7:0] data_bus_in,
    output logic [7:0] data_bus_out,
    output logic       irq,
    output logic [7:0] internal_data_bus,
    output logic       write_block_address_1,
    output logic       write_block_address_2,
    output logic       write_block_address_3,
    output logic       write_block_address_4,
    output logic       write_access_command,
    output logic       write_data,
    output logic       read_data,
    input  logic [7:0] read_data_byte,
    input  logic       drive_busy,
    input  logic       read_interface_error,
    input  logic       read_crc_error,
    input  logic       write_interface_error,
    input  logic       block_read_interrupt,
    input  logic       read_completion_interrupt,
    input  logic       request_write_data_interrupt,
    input  logic       write_completion_interrupt
);
    localparam int AW = $clog2(fifo_depth);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(block_bytes);
    localparam logic [CW-1:0] FIFO_FULL = CW'(fifo_depth);
    localparam logic [BW:0]   BLOCK_LEN = (BW+1)'(block_bytes);

    typedef enum logic [1:0] {W_IDLE, W_PRESENT, W_STROBE} wstate_t;

    logic          wr_prev_q, rd_prev_q;
    logic          wr_evt, rd_evt;
    logic [7:0]    wf_mem [fifo_depth];
    logic [7:0]    rf_mem [fifo_depth];
    logic [AW-1:0] wf_wp_q, wf_rp_q, rf_wp_q, rf_rp_q;
    logic [CW-1:0] wf_cnt_q, rf_cnt_q;
    logic          wf_full, wf_empty, rf_full, rf_empty;
    logic          wf_push, wf_pop, wf_ovf, rf_push, rf_pop, rf_unf;
    logic          pending_q;
    logic [7:0]    pend_byte_q, rd_byte;
    logic          rd_ovf;
    logic          cmd_ok, cmd_rej, addr_strobe, host_strobe, flush;
    logic [7:0]    status_q, status_d, status_set, status_clr, mask_q;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [BW:0]   cnt_sum;
    logic          blk_wrap;
    wstate_t       state_q;
    logic [7:0]    bus_q, wdata_q;
    logic [3:0]    wba_q;
    logic          cmd_q, wd_q, rdd_q, present_ok_q, go_strobe;

    // One internal event per host access: act only on the rising edge of the
    // qualified read/write levels.
    assign wr_evt = chip_select & io_write & ~wr_prev_q;
    assign rd_evt = chip_select & io_read  & ~rd_prev_q;

    assign wf_full  = (wf_cnt_q == FIFO_FULL);
    assign wf_empty = (wf_cnt_q == '0);
    assign rf_full  = (rf_cnt_q == FIFO_FULL);
    assign rf_empty = (rf_cnt_q == '0);

    assign cmd_ok      = wr_evt & (address == 3'd5) & ~drive_busy;
    assign cmd_rej     = wr_evt & (address == 3'd5) &  drive_busy;
    assign addr_strobe = wr_evt & (address >= 3'd1) & (address <= 3'd4);
    assign host_strobe = addr_strobe | cmd_ok;
    assign flush       = cmd_ok;

    assign wf_push = wr_evt & (address == 3'd0) & ~wf_full;
    assign wf_ovf  = wr_evt & (address == 3'd0) &  wf_full;
    assign wf_pop  = (state_q == W_IDLE) & request_write_data_interrupt & ~wf_empty;
    assign rf_pop  = rd_evt & (address == 3'd0) & ~rf_empty;
    assign rf_unf  = rd_evt & (address == 3'd0) &  rf_empty;

    // A held byte has priority over a fresh one; a pulse landing while a byte
    // is already held has nowhere to go and is counted as overflow.
    assign rd_byte = pending_q ? pend_byte_q : read_data_byte;
    assign rf_push = (pending_q | block_read_interrupt) & ~rf_full & ~flush;
    assign rd_ovf  = pending_q & block_read_interrupt;

    // The transfer only strobes after its byte has owned the bus for a full cycle.
    assign go_strobe = (state_q == W_PRESENT) & present_ok_q & ~host_strobe;

    always_comb begin
        cnt_sum    = {1'b0, byte_cnt_q} + (BW+1)'(rf_push) + (BW+1)'(go_strobe);
        blk_wrap   = (cnt_sum >= BLOCK_LEN) & ~flush;
        byte_cnt_d = byte_cnt_q;
        if (flush)
            byte_cnt_d = '0;
        else if (blk_wrap)
            byte_cnt_d = BW'(cnt_sum - BLOCK_LEN);
        else
            byte_cnt_d = BW'(cnt_sum);
    end

    always_comb begin
        status_set = {1'b0, cmd_rej, wf_ovf | rf_unf | rd_ovf, blk_wrap,
                      read_interface_error | read_crc_error | write_interface_error,
                      write_completion_interrupt, read_completion_interrupt, rf_push};
        status_clr = (wr_evt && address == 3'd6) ? data_bus_in : 8'h00;
        // Set after clear so a same-cycle event is never lost.
        status_d   = (status_q & ~status_clr) | status_set;
    end

    always_comb begin
        case (address)
            3'd0:    data_bus_out = rf_empty ? 8'h00 : rf_mem[rf_rp_q];
            3'd6:    data_bus_out = status_q;
            3'd7:    data_bus_out = mask_q;
            default: data_bus_out = {drive_busy, wf_full, rf_empty, 5'b0};
        endcase
    end

    assign irq = |(status_q & mask_q);

    always_ff @(posedge clock) begin
        if (wf_push) wf_mem[wf_wp_q] <= data_bus_in;
        if (rf_push) rf_mem[rf_wp_q] <= rd_byte;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_prev_q   <= 1'b0;
            rd_prev_q   <= 1'b0;
            wf_wp_q     <= '0;
            wf_rp_q     <= '0;
            wf_cnt_q    <= '0;
            rf_wp_q     <= '0;
            rf_rp_q     <= '0;
            rf_cnt_q    <= '0;
            pending_q   <= 1'b0;
            pend_byte_q <= 8'h00;
            status_q    <= 8'h00;
            mask_q      <= 8'h00;
            byte_cnt_q  <= '0;
            rdd_q       <= 1'b0;
        end else begin
            wr_prev_q  <= chip_select & io_write;
            rd_prev_q  <= chip_select & io_read;
            status_q   <= status_d;
            byte_cnt_q <= byte_cnt_d;
            rdd_q      <= rf_push;
            if (wr_evt && address == 3'd7) mask_q <= data_bus_in;

            if (rf_push) begin
                pending_q <= 1'b0;
            end else if (block_read_interrupt && !pending_q) begin
                pending_q   <= 1'b1;
                pend_byte_q <= read_data_byte;
            end

            if (flush) begin
                wf_wp_q  <= '0;
                wf_rp_q  <= '0;
                wf_cnt_q <= '0;
                rf_wp_q  <= '0;
                rf_rp_q  <= '0;
                rf_cnt_q <= '0;
            end else begin
                if (wf_push) wf_wp_q <= wf_wp_q + 1'b1;
                if (wf_pop)  wf_rp_q <= wf_rp_q + 1'b1;
                if (wf_push && !wf_pop)      wf_cnt_q <= wf_cnt_q + 1'b1;
                else if (wf_pop && !wf_push) wf_cnt_q <= wf_cnt_q - 1'b1;
                if (rf_push) rf_wp_q <= rf_wp_q + 1'b1;
                if (rf_pop)  rf_rp_q <= rf_rp_q + 1'b1;
                if (rf_push && !rf_pop)      rf_cnt_q <= rf_cnt_q + 1'b1;
                else if (rf_pop && !rf_push) rf_cnt_q <= rf_cnt_q - 1'b1;
            end
        end
    end

    // Bus owner, host strobes and write-path FSM share one register set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= W_IDLE;
            bus_q        <= 8'h00;
            wdata_q      <= 8'h00;
            wba_q        <= 4'b0000;
            cmd_q        <= 1'b0;
            wd_q         <= 1'b0;
            present_ok_q <= 1'b0;
        end else begin
            wba_q <= 4'b0000;
            cmd_q <= 1'b0;
            wd_q  <= 1'b0;
            if (host_strobe) begin
                bus_q <= data_bus_in;
                case (address)
                    3'd1:    wba_q <= 4'b0001;
                    3'd2:    wba_q <= 4'b0010;
                    3'd3:    wba_q <= 4'b0100;
                    3'd4:    wba_q <= 4'b1000;
                    default: cmd_q <= 1'b1;
                endcase
            end
            case (state_q)
                W_IDLE: begin
                    if (wf_pop) begin
                        wdata_q      <= wf_mem[wf_rp_q];
                        state_q      <= W_PRESENT;
                        present_ok_q <= ~host_strobe;
                        if (!host_strobe) bus_q <= wf_mem[wf_rp_q];
                    end
                end
                W_PRESENT: begin
                    if (host_strobe) begin
                        present_ok_q <= 1'b0;
                    end else if (!present_ok_q) begin
                        bus_q        <= wdata_q;
                        present_ok_q <= 1'b1;
                    end else begin
                        state_q <= W_STROBE;
                        wd_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= W_IDLE;
                end
            endcase
        end
    end

    assign internal_data_bus     = bus_q;
    assign write_block_address_1 = wba_q[0];
    assign write_block_address_2 = wba_q[1];
    assign write_block_address_3 = wba_q[2];
    assign write_block_address_4 = wba_q[3];
    assign write_access_command  = cmd_q;
    assign write_data            = wd_q;
    assign read_data             = rdd_q;

endmodule

// File: tb/tb_kfmmc_host_bridge.sv
// Directed bench for kfmmc_host_bridge: register strobes, command rejection,
// read path block/backpressure, write path with bus collision, reset mid-write.
module tb_kfmmc_host_bridge;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       chip_select = 1'b0;
    logic [2:0] address = 3'd0;
    logic       io_read = 1'b0;
    logic       io_write = 1'b0;
    logic [7:0] data_bus_in = 8'h00;
    logic [7:0] data_bus_out;
    logic       irq;
    logic [7:0] internal_data_bus;
    logic       write_block_address_1, write_block_address_2;
    logic       write_block_address_3, write_block_address_4;
    logic       write_access_command, write_data, read_data;
    logic [7:0] read_data_byte = 8'h00;
    logic       drive_busy = 1'b0;
    logic       read_interface_error = 1'b0;
    logic       read_crc_error = 1'b0;
    logic       write_interface_error = 1'b0;
    logic       block_read_interrupt = 1'b0;
    logic       read_completion_interrupt = 1'b0;
    logic       request_write_data_interrupt = 1'b0;
    logic       write_completion_interrupt = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    int         n_wba [4];
    logic [7:0] v_wba [4];
    int         n_cmd = 0;
    logic [7:0] v_cmd = 8'h00;
    int         n_wd  = 0;
    logic [7:0] wd_log [16];
    int         n_rdd = 0;

    kfmmc_host_bridge #(.fifo_depth(4), .block_bytes(512)) dut (
        .clock(clock), .reset(reset), .chip_select(chip_select), .address(address),
        .io_read(io_read), .io_write(io_write), .data_bus_in(data_bus_in),
        .data_bus_out(data_bus_out), .irq(irq), .internal_data_bus(internal_data_bus),
        .write_block_address_1(write_block_address_1),
        .write_block_address_2(write_block_address_2),
        .write_block_address_3(write_block_address_3),
        .write_block_address_4(write_block_address_4),
        .write_access_command(write_access_command), .write_data(write_data),
        .read_data(read_data), .read_data_byte(read_data_byte), .drive_busy(drive_busy),
        .read_interface_error(read_interface_error), .read_crc_error(read_crc_error),
        .write_interface_error(write_interface_error),
        .block_read_interrupt(block_read_interrupt),
        .read_completion_interrupt(read_completion_interrupt),
        .request_write_data_interrupt(request_write_data_interrupt),
        .write_completion_interrupt(write_completion_interrupt)
    );

    always #5 clock = ~clock;

    initial begin
        for (int k = 0; k < 4; k++) begin
            n_wba[k] = 0;
            v_wba[k] = 8'h00;
        end
    end

    always @(negedge clock) begin
        if (write_block_address_1) begin n_wba[0]++; v_wba[0] = internal_data_bus; end
        if (write_block_address_2) begin n_wba[1]++; v_wba[1] = internal_data_bus; end
        if (write_block_address_3) begin n_wba[2]++; v_wba[2] = internal_data_bus; end
        if (write_block_address_4) begin n_wba[3]++; v_wba[3] = internal_data_bus; end
        if (write_access_command) begin n_cmd++; v_cmd = internal_data_bus; end
        if (write_data) begin
            if (n_wd < 16) wd_log[n_wd] = internal_data_bus;
            n_wd++;
        end
        if (read_data) n_rdd++;
    end

    task automatic host_write(input logic [2:0] a, input logic [7:0] d);
        @(posedge clock); #1;
        chip_select = 1'b1; address = a; data_bus_in = d; io_write = 1'b1;
        @(posedge clock); #1;
        io_write = 1'b0; chip_select = 1'b0;
    endtask

    task automatic host_read(input logic [2:0] a, output logic [7:0] d);
        @(posedge clock); #1;
        chip_select = 1'b1; address = a; io_read = 1'b1;
        #3;
        d = data_bus_out;
        @(posedge clock); #1;
        io_read = 1'b0; chip_select = 1'b0;
    endtask

    task automatic drive_pulse(input logic [7:0] b);
        @(posedge clock); #1;
        block_read_interrupt = 1'b1; read_data_byte = b;
        @(posedge clock); #1;
        block_read_interrupt = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic [7:0] outs;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        outs = {write_block_address_1, write_block_address_2, write_block_address_3,
                write_block_address_4, write_access_command, write_data, read_data, irq};
        n_checks++;
        if (outs !== 8'h00) $display("FAIL reset_strobes got=%h exp=00", outs);
        else n_pass++;
        n_checks++;
        if (internal_data_bus !== 8'h00) $display("FAIL reset_bus got=%h exp=00", internal_data_bus);
        else n_pass++;
        n_checks++;
        if (data_bus_out !== 8'h00) $display("FAIL reset_reg0 got=%h exp=00", data_bus_out);
        else n_pass++;
        reset = 1'b1;
        host_read(3'd6, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL reset_status got=%h exp=00", d);
        else n_pass++;
        host_read(3'd7, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL reset_mask got=%h exp=00", d);
        else n_pass++;
        host_read(3'd1, d);
        n_checks++;
        if (d !== 8'h20) $display("FAIL reset_flags got=%h exp=20", d);
        else n_pass++;
    endtask

    task automatic test_addr_cmd();
        logic [7:0] d;
        logic [7:0] exp_a [4];
        exp_a[0] = 8'h12; exp_a[1] = 8'h34; exp_a[2] = 8'h56; exp_a[3] = 8'h78;
        drive_busy = 1'b0;
        drive_pulse(8'h01);
        drive_pulse(8'h02);
        drive_pulse(8'h03);
        n_checks++;
        if (dut.byte_cnt_q !== 9'd3) $display("FAIL pre_cmd_count got=%0d exp=3", dut.byte_cnt_q);
        else n_pass++;
        for (int k = 0; k < 4; k++) host_write(3'(k + 1), exp_a[k]);
        host_write(3'd5, 8'h01);
        repeat (2) @(posedge clock);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (n_wba[k] !== 1) $display("FAIL wba%0d_count got=%0d exp=1", k + 1, n_wba[k]);
            else n_pass++;
            n_checks++;
            if (v_wba[k] !== exp_a[k]) $display("FAIL wba%0d_data got=%h exp=%h", k + 1, v_wba[k], exp_a[k]);
            else n_pass++;
        end
        n_checks++;
        if (n_cmd !== 1) $display("FAIL cmd_count got=%0d exp=1", n_cmd);
        else n_pass++;
        n_checks++;
        if (v_cmd !== 8'h01) $display("FAIL cmd_data got=%h exp=01", v_cmd);
        else n_pass++;
        n_checks++;
        if (dut.byte_cnt_q !== 9'd0) $display("FAIL cmd_count_clear got=%0d exp=0", dut.byte_cnt_q);
        else n_pass++;
        host_read(3'd1, d);
        n_checks++;
        if (d !== 8'h20) $display("FAIL cmd_flush got=%h exp=20", d);
        else n_pass++;
    endtask

    task automatic test_cmd_reject();
        logic [7:0] d;
        int base;
        host_write(3'd6, 8'hFF);
        drive_busy = 1'b1;
        base = n_cmd;
        host_write(3'd5, 8'h02);
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (n_cmd !== base) $display("FAIL reject_no_cmd got=%0d exp=%0d", n_cmd, base);
        else n_pass++;
        host_read(3'd1, d);
        n_checks++;
        if (d !== 8'hA0) $display("FAIL reject_busy_flag got=%h exp=a0", d);
        else n_pass++;
        host_read(3'd6, d);
        n_checks++;
        if (d !== 8'h40) $display("FAIL reject_status got=%h exp=40", d);
        else n_pass++;
        host_write(3'd6, 8'h40);
        host_read(3'd6, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL reject_w1c got=%h exp=00", d);
        else n_pass++;
        drive_busy = 1'b0;
    endtask

    task automatic test_read_block();
        logic [7:0] d;
        int base;
        host_write(3'd6, 8'hFF);
        host_write(3'd7, 8'h10);
        base = n_rdd;
        for (int i = 0; i < 512; i++) begin
            drive_pulse(8'(i));
            host_read(3'd0, d);
            n_checks++;
            if (d !== 8'(i)) $display("FAIL block_byte%0d got=%h exp=%h", i, d, 8'(i));
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if (irq !== 1'b0) $display("FAIL block_irq_early got=%b exp=0", irq);
                else n_pass++;
            end
        end
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (n_rdd - base !== 512) $display("FAIL block_read_data got=%0d exp=512", n_rdd - base);
        else n_pass++;
        host_read(3'd6, d);
        n_checks++;
        if (d !== 8'h11) $display("FAIL block_status got=%h exp=11", d);
        else n_pass++;
        n_checks++;
        if (irq !== 1'b1) $display("FAIL block_irq got=%b exp=1", irq);
        else n_pass++;
    endtask

    task automatic test_read_backpressure();
        logic [7:0] d;
        int base;
        host_write(3'd6, 8'hFF);
        base = n_rdd;
        for (int k = 0; k < 5; k++) drive_pulse(8'hC0 + 8'(k));
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (n_rdd - base !== 4) $display("FAIL bp_accept4 got=%0d exp=4", n_rdd - base);
        else n_pass++;
        host_read(3'd1, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL bp_flags got=%h exp=00", d);
        else n_pass++;
        host_read(3'd0, d);
        n_checks++;
        if (d !== 8'hC0) $display("FAIL bp_head got=%h exp=c0", d);
        else n_pass++;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (n_rdd - base !== 5) $display("FAIL bp_pending_accept got=%0d exp=5", n_rdd - base);
        else n_pass++;
        host_read(3'd6, d);
        n_checks++;
        if (d !== 8'h01) $display("FAIL bp_status_clean got=%h exp=01", d);
        else n_pass++;
        drive_pulse(8'hC5);
        drive_pulse(8'hC6);
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (n_rdd - base !== 5) $display("FAIL bp_held got=%0d exp=5", n_rdd - base);
        else n_pass++;
        host_read(3'd6, d);
        n_checks++;
        if (d !== 8'h21) $display("FAIL bp_overflow got=%h exp=21", d);
        else n_pass++;
        for (int k = 1; k < 6; k++) begin
            host_read(3'd0, d);
            n_checks++;
            if (d !== 8'hC0 + 8'(k)) $display("FAIL bp_drain%0d got=%h exp=%h", k, d, 8'hC0 + 8'(k));
            else n_pass++;
        end
        n_checks++;
        if (n_rdd - base !== 6) $display("FAIL bp_total got=%0d exp=6", n_rdd - base);
        else n_pass++;
    endtask

    task automatic test_write_collision();
        int base_wd;
        int base_wba;
        int waited;
        host_write(3'd6, 8'hFF);
        host_write(3'd0, 8'hA5);
        host_write(3'd0, 8'h5A);
        base_wd  = n_wd;
        base_wba = n_wba[1];
        @(posedge clock); #1;
        request_write_data_interrupt = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (internal_data_bus !== 8'hA5 || write_data !== 1'b0)
            $display("FAIL wr_present got=%h/%b exp=a5/0", internal_data_bus, write_data);
        else n_pass++;
        chip_select = 1'b1; address = 3'd2; data_bus_in = 8'h3C; io_write = 1'b1;
        @(posedge clock); #1;
        io_write = 1'b0; chip_select = 1'b0;
        n_checks++;
        if (internal_data_bus !== 8'h3C || write_block_address_2 !== 1'b1 || write_data !== 1'b0)
            $display("FAIL wr_host_strobe got=%h/%b/%b exp=3c/1/0",
                     internal_data_bus, write_block_address_2, write_data);
        else n_pass++;
        @(posedge clock); #1;
        n_checks++;
        if (internal_data_bus !== 8'hA5 || write_data !== 1'b0)
            $display("FAIL wr_represent got=%h/%b exp=a5/0", internal_data_bus, write_data);
        else n_pass++;
        @(posedge clock); #1;
        n_checks++;
        if (internal_data_bus !== 8'hA5 || write_data !== 1'b1)
            $display("FAIL wr_strobe got=%h/%b exp=a5/1", internal_data_bus, write_data);
        else n_pass++;
        waited = 0;
        while (n_wd - base_wd < 2 && waited < 20) begin
            @(posedge clock); #1;
            waited++;
        end
        repeat (2) @(posedge clock);
        #1;
        request_write_data_interrupt = 1'b0;
        n_checks++;
        if (n_wd - base_wd !== 2) $display("FAIL wr_count got=%0d exp=2", n_wd - base_wd);
        else n_pass++;
        n_checks++;
        if (wd_log[base_wd] !== 8'hA5) $display("FAIL wr_byte0 got=%h exp=a5", wd_log[base_wd]);
        else n_pass++;
        n_checks++;
        if (wd_log[base_wd + 1] !== 8'h5A) $display("FAIL wr_byte1 got=%h exp=5a", wd_log[base_wd + 1]);
        else n_pass++;
        n_checks++;
        if (n_wba[1] - base_wba !== 1 || v_wba[1] !== 8'h3C)
            $display("FAIL wr_wba2 got=%0d/%h exp=1/3c", n_wba[1] - base_wba, v_wba[1]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] d;
        logic [7:0] outs;
        int base;
        host_write(3'd0, 8'h77);
        host_write(3'd0, 8'h99);
        base = n_wd;
        @(posedge clock); #1;
        request_write_data_interrupt = 1'b1;
        @(posedge clock); #1;
        n_checks++;
        if (internal_data_bus !== 8'h77) $display("FAIL rst_present got=%h exp=77", internal_data_bus);
        else n_pass++;
        #3;
        reset = 1'b0;
        #1;
        outs = {write_block_address_1, write_block_address_2, write_block_address_3,
                write_block_address_4, write_access_command, write_data, read_data, irq};
        n_checks++;
        if (outs !== 8'h00 || internal_data_bus !== 8'h00)
            $display("FAIL rst_outputs got=%h/%h exp=00/00", outs, internal_data_bus);
        else n_pass++;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        n_checks++;
        if (n_wd !== base) $display("FAIL rst_no_write_data got=%0d exp=%0d", n_wd, base);
        else n_pass++;
        n_checks++;
        if (internal_data_bus !== 8'h00) $display("FAIL rst_bus_idle got=%h exp=00", internal_data_bus);
        else n_pass++;
        host_read(3'd6, d);
        n_checks++;
        if (d !== 8'h00) $display("FAIL rst_status got=%h exp=00", d);
        else n_pass++;
        host_read(3'd1, d);
        n_checks++;
        if (d !== 8'h20) $display("FAIL rst_flags got=%h exp=20", d);
        else n_pass++;
        request_write_data_interrupt = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addr_cmd();
        test_cmd_reject();
        test_read_block();
        test_read_backpressure();
        test_write_collision();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
